// File: rtl/if_fetch_ctrl_p.sv
// IF-stage fetch controller: address checking, L1 cache path, uncached bus path
// with timeout, and a small cache-error-handler instruction buffer refilled from the bus.
module if_fetch_ctrl_p #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INS_W       = 32,
    parameter int unsigned       EBUF_DEPTH  = 16,
    parameter logic [ADDR_W-1:0] EBUF_BASE   = 32'hBFC0_0200,
    parameter logic [ADDR_W-1:0] TEXT_HI     = 32'h7FFF_FFFF,
    parameter logic [ADDR_W-1:0] MEM_HI      = 32'hFFFF_FFFF,
    parameter logic [ADDR_W-1:0] UNC_LO      = 32'hA000_0000,
    parameter logic [ADDR_W-1:0] UNC_HI      = 32'hBFFF_FFFF,
    parameter int unsigned       BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              um,
    input  logic              erl,
    input  logic              flush,
    output logic              fetch_done,
    output logic [INS_W-1:0]  ins,
    output logic              addr_err,
    output logic              bus_err,
    output logic              cache_err,
    output logic              cache_rd,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_ack,
    input  logic [INS_W-1:0]  cache_data,
    input  logic              cache_err_in,
    input  logic              cache_bus_err_in,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as,
    output logic              bus_rw,
    input  logic              bus_ack,
    input  logic [INS_W-1:0]  bus_rdata,
    input  logic              ebuf_inval
);

    localparam int unsigned IDX_W = $clog2(EBUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [ADDR_W:0] EBUF_END = {1'b0, EBUF_BASE} + (ADDR_W+1)'(EBUF_DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CACHE    = 2'd1,
        S_BUS_REQ  = 2'd2,
        S_BUS_WAIT = 2'd3
    } state_e;

    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        in_win = ({1'b0, a} >= {1'b0, EBUF_BASE}) && ({1'b0, a} < EBUF_END);
    endfunction

    function automatic logic [IDX_W-1:0] win_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off     = a - EBUF_BASE;
        win_idx = off[IDX_W+1:2];
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic [EBUF_DEPTH-1:0] valid_q, valid_d;
    logic [INS_W-1:0]    ebuf_q [EBUF_DEPTH];
    logic                fetch_done_q, fetch_done_d;
    logic [INS_W-1:0]    ins_q, ins_d;
    logic                addr_err_q, addr_err_d;
    logic                bus_err_q, bus_err_d;
    logic                cache_err_q, cache_err_d;
    logic                cache_rd_q, cache_rd_d;
    logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
    logic                bus_req_q, bus_req_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_as_q, bus_as_d;
    logic                bus_rw_q, bus_rw_d;

    logic                accept_s, pc_unc_s, addr_bad_s, ebuf_hit_s;
    logic                timeout_s, suppress_s, ebuf_we_s;
    logic [IDX_W-1:0]    rd_idx_s, wr_idx_s;

    assign accept_s   = (state_q == S_IDLE) && fetch_req && !flush;
    assign pc_unc_s   = (pc >= UNC_LO) && (pc <= UNC_HI);
    assign addr_bad_s = (pc[1:0] != 2'b00) || (um && (pc > TEXT_HI)) ||
                        (!um && (pc > MEM_HI)) || (!um && erl && !pc_unc_s);
    assign rd_idx_s   = win_idx(pc);
    assign ebuf_hit_s = pc_unc_s && in_win(pc) && valid_q[rd_idx_s] && !ebuf_inval;
    assign wr_idx_s   = win_idx(pc_q);
    assign timeout_s  = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
    assign suppress_s = flush_pend_q || flush;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            fetch_done_q <= 1'b0;
            ins_q        <= '0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            cache_err_q  <= 1'b0;
            cache_rd_q   <= 1'b0;
            cache_addr_q <= '0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_as_q     <= 1'b0;
            bus_rw_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            fetch_done_q <= fetch_done_d;
            ins_q        <= ins_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
            cache_err_q  <= cache_err_d;
            cache_rd_q   <= cache_rd_d;
            cache_addr_q <= cache_addr_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_as_q     <= bus_as_d;
            bus_rw_q     <= bus_rw_d;
        end
    end

    // Buffer data array; contents are only meaningful where a valid bit is set
    always_ff @(posedge clk) begin
        if (!resetn && ebuf_we_s) begin
            ebuf_q[wr_idx_s] <= bus_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && !addr_bad_s && !ebuf_hit_s) begin
                    state_d = pc_unc_s ? S_BUS_REQ : S_CACHE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CACHE: begin
                if (flush || cache_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CACHE;
                end
            end
            S_BUS_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (bus_grant) begin
                    state_d = S_BUS_WAIT;
                end else begin
                    state_d = S_BUS_REQ;
                end
            end
            S_BUS_WAIT: begin
                if (bus_ack || timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUS_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        pc_d         = accept_s ? pc : pc_q;
        cnt_d        = '0;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        ebuf_we_s    = 1'b0;
        fetch_done_d = 1'b0;
        ins_d        = ins_q;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;
        cache_err_d  = 1'b0;
        cache_addr_d = cache_addr_q;
        bus_addr_d   = bus_addr_q;
        bus_rw_d     = 1'b0;
        cache_rd_d   = (state_d == S_CACHE);
        bus_req_d    = (state_d == S_BUS_REQ);
        bus_as_d     = (state_d == S_BUS_WAIT);
        case (state_q)
            S_IDLE: begin
                flush_pend_d = 1'b0;
                if (accept_s) begin
                    if (addr_bad_s) begin
                        fetch_done_d = 1'b1;
                        addr_err_d   = 1'b1;
                        ins_d        = '0;
                    end else if (ebuf_hit_s) begin
                        fetch_done_d = 1'b1;
                        ins_d        = ebuf_q[rd_idx_s];
                    end else if (pc_unc_s) begin
                        bus_addr_d   = pc;
                    end else begin
                        cache_addr_d = pc;
                    end
                end else begin
                    fetch_done_d = 1'b0;
                end
            end
            S_CACHE: begin
                if (!flush && cache_ack) begin
                    fetch_done_d = 1'b1;
                    ins_d        = cache_data;
                    cache_err_d  = cache_err_in;
                    bus_err_d    = cache_bus_err_in;
                end else begin
                    fetch_done_d = 1'b0;
                end
            end
            S_BUS_REQ: begin
                fetch_done_d = 1'b0;
            end
            S_BUS_WAIT: begin
                cnt_d        = cnt_q + CNT_W'(1);
                flush_pend_d = suppress_s;
                if (bus_ack) begin
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                    ebuf_we_s    = in_win(pc_q);
                    if (!suppress_s) begin
                        fetch_done_d = 1'b1;
                        ins_d        = bus_rdata;
                    end else begin
                        fetch_done_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                    if (!suppress_s) begin
                        fetch_done_d = 1'b1;
                        bus_err_d    = 1'b1;
                        ins_d        = '0;
                    end else begin
                        fetch_done_d = 1'b0;
                    end
                end else begin
                    fetch_done_d = 1'b0;
                end
            end
            default: fetch_done_d = 1'b0;
        endcase
        // Invalidate wins over a same-cycle refill so the entry stays invalid
        if (ebuf_inval) begin
            valid_d = '0;
        end else if (ebuf_we_s) begin
            valid_d[wr_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    assign fetch_done = fetch_done_q;
    assign ins        = ins_q;
    assign addr_err   = addr_err_q;
    assign bus_err    = bus_err_q;
    assign cache_err  = cache_err_q;
    assign cache_rd   = cache_rd_q;
    assign cache_addr = cache_addr_q;
    assign bus_req    = bus_req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_as     = bus_as_q;
    assign bus_rw     = bus_rw_q;

endmodule

// File: tb/tb_if_fetch_ctrl_p.sv
// Scoreboard bench for if_fetch_ctrl_p: expected fetch results are queued at issue
// and compared whenever fetch_done is seen.
module tb_if_fetch_ctrl_p;

    localparam logic [31:0] EBUF_BASE = 32'hBFC0_0200;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        um = 1'b0, erl = 1'b0, flush = 1'b0;
    logic        fetch_done;
    logic [31:0] ins;
    logic        addr_err, bus_err, cache_err;
    logic        cache_rd;
    logic [31:0] cache_addr;
    logic        cache_ack = 1'b0;
    logic [31:0] cache_data = 32'h0;
    logic        cache_err_in = 1'b0, cache_bus_err_in = 1'b0;
    logic        bus_req;
    logic        bus_grant = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_as, bus_rw;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        ebuf_inval = 1'b0;

    typedef struct packed {
        logic [31:0] ins;
        logic        ae;
        logic        be;
        logic        ce;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    if_fetch_ctrl_p dut (
        .clk(clk), .resetn(resetn), .fetch_req(fetch_req), .pc(pc), .um(um), .erl(erl),
        .flush(flush), .fetch_done(fetch_done), .ins(ins), .addr_err(addr_err),
        .bus_err(bus_err), .cache_err(cache_err), .cache_rd(cache_rd),
        .cache_addr(cache_addr), .cache_ack(cache_ack), .cache_data(cache_data),
        .cache_err_in(cache_err_in), .cache_bus_err_in(cache_bus_err_in),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_as(bus_as),
        .bus_rw(bus_rw), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ebuf_inval(ebuf_inval)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic ae, input logic be, input logic ce);
        exp_t e;
        e.ins = i; e.ae = ae; e.be = be; e.ce = ce;
        sb.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] a, input logic u, input logic e);
        pc = a; um = u; erl = e; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; um = 1'b0; erl = 1'b0;
    endtask

    // Entered in the cycle after acceptance; leaves in the cycle after bus_ack.
    task automatic bus_serve(input int gdly, input int adly, input logic [31:0] d,
                             input logic flush_mid, input logic inval_at_ack);
        check_eq("bus_req_up", {63'd0, bus_req}, 64'd1);
        repeat (gdly) tick();
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check_eq("bus_as_req_rw", {61'd0, bus_as, bus_req, bus_rw}, 64'd4);
        if (flush_mid) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        repeat (adly) tick();
        bus_ack = 1'b1; bus_rdata = d; ebuf_inval = inval_at_ack;
        tick();
        bus_ack = 1'b0; ebuf_inval = 1'b0;
    endtask

    // Scoreboard: every fetch_done must match the oldest queued expectation
    always @(negedge clk) begin
        if (!resetn && fetch_done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", {63'd0, fetch_done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_ins", {32'd0, ins}, {32'd0, e.ins});
                check_eq("done_flags", {61'd0, addr_err, bus_err, cache_err},
                         {61'd0, e.ae, e.be, e.ce});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        repeat (3) tick();
        check_eq("rst_flags", {56'd0, fetch_done, addr_err, bus_err, cache_err,
                               cache_rd, bus_req, bus_as, bus_rw}, 64'd0);
        check_eq("rst_ins", {32'd0, ins}, 64'd0);
        check_eq("rst_addrs", {cache_addr, bus_addr}, 64'd0);
        resetn = 1'b0;
        tick();

        // Address errors, issued back to back
        push(32'h0, 1'b1, 1'b0, 1'b0);
        fetch(32'h8000_0002, 1'b0, 1'b0);
        check_eq("ae_misalign_lat", {63'd0, fetch_done}, 64'd1);
        push(32'h0, 1'b1, 1'b0, 1'b0);
        fetch(32'h8000_0000, 1'b1, 1'b0);
        check_eq("ae_user_b2b", {63'd0, fetch_done}, 64'd1);
        push(32'h0, 1'b1, 1'b0, 1'b0);
        fetch(32'h8000_1000, 1'b0, 1'b1);
        check_eq("ae_erl_cached", {62'd0, fetch_done, cache_rd}, 64'd2);
        tick();
        check_eq("ae_pulse", {63'd0, fetch_done}, 64'd0);

        // Cached fetch, ack in the third cache_rd cycle
        push(32'h2402_0001, 1'b0, 1'b0, 1'b0);
        fetch(32'h8000_1000, 1'b0, 1'b0);
        check_eq("cache_addr", {32'd0, cache_addr}, 64'h8000_1000);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (cache_rd) cnt++;
            if (i == 2) begin
                cache_ack = 1'b1; cache_data = 32'h2402_0001;
            end
            tick();
        end
        cache_ack = 1'b0;
        check_eq("cache_rd_cycles", cnt, 64'd3);
        check_eq("cache_done", {62'd0, fetch_done, cache_rd}, 64'd2);
        tick();

        // Cached fetch with L1 error flags
        push(32'h0000_00AA, 1'b0, 1'b1, 1'b1);
        fetch(32'h0040_0000, 1'b1, 1'b0);
        cache_ack = 1'b1; cache_data = 32'h0000_00AA;
        cache_err_in = 1'b1; cache_bus_err_in = 1'b1;
        tick();
        cache_ack = 1'b0; cache_err_in = 1'b0; cache_bus_err_in = 1'b0;
        check_eq("cache_err_done", {63'd0, fetch_done}, 64'd1);
        tick();

        // Cold buffer miss, refill, then hit
        push(32'h1234_5678, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd8, 1'b0, 1'b0);
        check_eq("miss_bus_addr", {32'd0, bus_addr}, {32'd0, EBUF_BASE + 32'd8});
        bus_serve(2, 3, 32'h1234_5678, 1'b0, 1'b0);
        check_eq("refill_done", {63'd0, fetch_done}, 64'd1);
        push(32'h1234_5678, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd8, 1'b0, 1'b0);
        check_eq("hit_done_noreq", {62'd0, fetch_done, bus_req}, 64'd2);
        tick();

        // Invalidate in the same cycle as a lookup forces a miss
        ebuf_inval = 1'b1;
        push(32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd8, 1'b0, 1'b0);
        ebuf_inval = 1'b0;
        check_eq("inval_miss", {62'd0, fetch_done, bus_req}, 64'd1);
        // Invalidate during the refill write: data returned, entry left invalid
        bus_serve(0, 1, 32'hCAFE_0001, 1'b0, 1'b1);
        check_eq("inval_refill_done", {63'd0, fetch_done}, 64'd1);
        push(32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd8, 1'b0, 1'b0);
        check_eq("still_invalid", {62'd0, fetch_done, bus_req}, 64'd1);
        bus_serve(1, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
        push(32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd8, 1'b0, 1'b0);
        check_eq("rehit", {62'd0, fetch_done, bus_req}, 64'd2);
        tick();

        // Bus timeout
        push(32'h0, 1'b0, 1'b1, 1'b0);
        fetch(32'hB000_0000, 1'b0, 1'b0);
        tick();
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check_eq("to_as_up", {63'd0, bus_as}, 64'd1);
        n = 0;
        while (!fetch_done && n < 400) begin
            tick();
            n++;
        end
        check_eq("to_cycles", n, 64'd255);
        check_eq("to_as_down", {63'd0, bus_as}, 64'd0);
        tick();

        // Flush in CACHE
        fetch(32'h8000_2000, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_cache", {62'd0, cache_rd, fetch_done}, 64'd0);
        // fetch_req together with flush is ignored
        flush = 1'b1;
        fetch(32'h8000_3000, 1'b0, 1'b0);
        flush = 1'b0;
        check_eq("flush_req_ign", {61'd0, cache_rd, bus_req, fetch_done}, 64'd0);

        // Flush in BUS_WAIT: no result, buffer still written
        fetch(EBUF_BASE + 32'd12, 1'b0, 1'b0);
        bus_serve(0, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check_eq("flush_bw_nodone", {63'd0, fetch_done}, 64'd0);
        tick();
        push(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd12, 1'b0, 1'b0);
        check_eq("flush_bw_hit", {62'd0, fetch_done, bus_req}, 64'd2);
        tick();

        // Reset during BUS_WAIT
        fetch(32'hB000_0004, 1'b0, 1'b0);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check_eq("rst_bw_as", {63'd0, bus_as}, 64'd1);
        resetn = 1'b1;
        tick();
        check_eq("rst_bw_clear", {61'd0, bus_as, bus_req, fetch_done}, 64'd0);
        resetn = 1'b0;
        push(32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        fetch(EBUF_BASE + 32'd12, 1'b0, 1'b0);
        check_eq("rst_valid_cleared", {62'd0, fetch_done, bus_req}, 64'd1);
        bus_serve(0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
        check_eq("post_rst_done", {63'd0, fetch_done}, 64'd1);
        repeat (3) tick();

        check_eq("sb_empty", sb.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
